// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 register file, two registered read ports, one write port, r0 hardwired to zero
// Ports: clk_i/rst_i (sync, active-high); read_i samples addr_r1_i/addr_r2_i;
// write_i/addr_w_i/data_w_i write one entry; data_r1_o/data_r2_o registered read data;
// rd_valid_o pulses one cycle after each accepted read.
module reg_file_2r1w #(
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'h03FFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [4:0]  addr_r1_i,
  input  logic [4:0]  addr_r2_i,
  input  logic [4:0]  addr_w_i,
  input  logic [31:0] data_w_i,
  output logic [31:0] data_r1_o,
  output logic [31:0] data_r2_o,
  output logic        rd_valid_o
);
  logic [31:0] mem_q [1:31];
  logic [31:0] we;
  logic [31:0] rd1, rd2, data_r1_d, data_r2_d, data_r1_q, data_r2_q;
  logic        rd_valid_d, rd_valid_q;
  assign we = write_i ? 32'd1 << addr_w_i : '0;
  for (genvar g = 1; g < 32; g++) begin : g_ent
    always_ff @(posedge clk_i)
      if (rst_i) mem_q[g] <= (g == SP_INDEX) ? SP_RESET : '0;
      else if (we[g]) mem_q[g] <= data_w_i;
  end
  // index 0 falls through to the zero default; a matching write bypasses storage
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (addr_r1_i == 5'(i)) rd1 = we[i] ? data_w_i : mem_q[i];
      if (addr_r2_i == 5'(i)) rd2 = we[i] ? data_w_i : mem_q[i];
    end
    data_r1_d  = read_i ? rd1 : data_r1_q;
    data_r2_d  = read_i ? rd2 : data_r2_q;
    rd_valid_d = read_i;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      data_r1_q  <= '0;
      data_r2_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_r1_q  <= data_r1_d;
      data_r2_q  <= data_r2_d;
      rd_valid_q <= rd_valid_d;
    end
  assign data_r1_o  = data_r1_q;
  assign data_r2_o  = data_r2_q;
  assign rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed and random checks of reg_file_2r1w against an array model
module tb_reg_file_2r1w;
  logic        clk = 1'b0;
  logic        rst = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0]  a1 = '0, a2 = '0, aw = '0;
  logic [31:0] dw = '0;
  logic [31:0] r1, r2;
  logic        vld;
  logic [31:0] m [32];
  logic [31:0] e1 = '0, e2 = '0;
  logic        ev = 1'b0;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  reg_file_2r1w dut (
    .clk_i(clk), .rst_i(rst), .read_i(rd), .write_i(wr),
    .addr_r1_i(a1), .addr_r2_i(a2), .addr_w_i(aw), .data_w_i(dw),
    .data_r1_o(r1), .data_r2_o(r2), .rd_valid_o(vld)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] val(input logic [4:0] a);
    if (a == 0) return '0;
    if (wr && !rst && a == aw) return dw;
    return m[a];
  endfunction
  task automatic step(input logic s_rst, input logic s_rd, input logic s_wr,
                      input logic [4:0] s_a1, input logic [4:0] s_a2,
                      input logic [4:0] s_aw, input logic [31:0] s_dw);
    rst = s_rst; rd = s_rd; wr = s_wr; a1 = s_a1; a2 = s_a2; aw = s_aw; dw = s_dw;
    @(posedge clk);
    if (rst) begin
      foreach (m[i]) m[i] = (i == 29) ? 32'h03FFFFFF : 32'h0;
      e1 = '0; e2 = '0; ev = 1'b0;
    end else begin
      if (rd) begin e1 = val(a1); e2 = val(a2); end
      ev = rd;
      if (wr && aw != 0) m[aw] = dw;
    end
    #1;
    chk("data_r1", r1, e1);
    chk("data_r2", r2, e2);
    chk("rd_valid", 32'(vld), 32'(ev));
  endtask
  initial begin
    logic [31:0] old6, h1, h2;
    foreach (m[i]) m[i] = '0;
    step(1, 1, 1, 0, 0, 7, 32'hFFFFFFFF);
    chk("reset_valid", 32'(vld), 32'h0);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 5'(i), 5'(i), 0, 0);
      chk("reset_contents", r1, (i == 29) ? 32'h03FFFFFF : 32'h0);
    end
    for (int i = 1; i < 32; i++) step(0, 0, 1, 0, 0, 5'(i), 32'hA5A50000 + i);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 5'(i), 5'(31 - i), 0, 0);
      chk("sweep_r1", r1, (i == 0) ? 32'h0 : 32'hA5A50000 + i);
      chk("sweep_r2", r2, (i == 31) ? 32'h0 : 32'hA5A50000 + 31 - i);
    end
    step(0, 1, 1, 0, 0, 0, 32'hDEADBEEF);
    chk("r0_same_cycle", r1 | r2, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("r0_after", r1 | r2, 32'h0);
    step(0, 0, 1, 0, 0, 5, 32'h11111111);
    old6 = m[6];
    step(0, 1, 1, 5, 6, 5, 32'h22222222);
    chk("bypass_r1", r1, 32'h22222222);
    chk("bypass_r2", r2, old6);
    step(0, 1, 0, 5, 5, 0, 0);
    chk("bypass_after", r1, 32'h22222222);
    step(0, 1, 0, 3, 4, 0, 0);
    h1 = r1; h2 = r2;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 5'(3 + (i % 2)), $urandom);
      chk("hold_r1", r1, h1);
      chk("hold_r2", r2, h2);
      chk("hold_valid", 32'(vld), 32'h0);
    end
    step(0, 0, 1, 0, 0, 7, 32'h12345678);
    step(0, 1, 0, 7, 7, 0, 0);
    chk("pre_reset", r1, 32'h12345678);
    step(1, 1, 1, 29, 7, 29, 32'hCAFEF00D);
    chk("midreset_out", r1 | r2, 32'h0);
    step(0, 1, 0, 29, 7, 0, 0);
    chk("midreset_sp", r1, 32'h03FFFFFF);
    chk("midreset_r7", r2, 32'h0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           5'($urandom), 5'($urandom), 5'($urandom_range(0, 7)), $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

32-entry × 32-bit register file with two registered read ports and one write port. It sits directly downstream of the control unit's register-fetch and write-back phases and consumes the 5-bit register indices and write-back data that control produces. Read data feeds the ALU operand muxes one cycle later. Register 0 is hardwired to zero; the stack-pointer entry resets to a programmable pattern.

## Interface
- SP_INDEX, default 29: index of the stack-pointer register.
- SP_RESET, default 32'h03FFFFFF: reset value of entry SP_INDEX.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  reset, synchronous and active-high.
- READ  input  1  read enable; samples both read addresses at the rising edge.
- WRITE  input  1  write enable.
- ADDR_R1  input  5  read port 1 index.
- ADDR_R2  input  5  read port 2 index.
- ADDR_W  input  5  write index.
- DATA_W  input  32  write data.
- DATA_R1  output  32  read port 1 data (registered).
- DATA_R2  output  32  read port 2 data (registered).
- RD_VALID  output  1  pulses high for one cycle after each accepted read.

## Operation
- Storage: 31 physical 32-bit registers for indices 1..31. Index 0 has no storage and always reads 0.
- Write: at a rising edge with WRITE=1 and ADDR_W≠0, entry[ADDR_W] ← DATA_W.
  - A write to index 0 is silently discarded.
  - The write address is decoded one-hot (5→32), and the decoded line gates each entry's load.
- Read: at a rising edge with READ=1:
  - DATA_R1 ← value(ADDR_R1) and DATA_R2 ← value(ADDR_R2).
  - RD_VALID ← 1.
- Read with READ=0: DATA_R1 and DATA_R2 hold their previous values, and RD_VALID ← 0.
- Write-first bypass: if READ=1 and WRITE=1 in the same cycle with ADDR_Rx = ADDR_W ≠ 0, DATA_Rx ← DATA_W, not the stale entry.
- Index 0 precedence: if ADDR_Rx = 0, DATA_Rx ← 0 regardless of any write.
- Both read ports may address the same index; both return the same value.
- No arithmetic; all data paths are 32-bit, with no width conversion.

## Timing
- Reset, taking effect at the first rising edge with RESET=1:
  - all entries ← 0, except entry SP_INDEX ← SP_RESET;
  - DATA_R1 = DATA_R2 = 32'h0;
  - RD_VALID = 0.
- Reset dominates READ and WRITE in the same cycle: the write is lost and no read is accepted.
- Reset mid-operation: any read result already presented is cleared to 0 on the reset edge. The first read after RESET deasserts returns the reset contents.
- Write latency: data written at edge N is visible to a read sampled at edge N through the bypass. It is visible from storage at edge N+1 onward.
- Read latency: one cycle. The address is sampled at edge N, and DATA_Rx/RD_VALID are valid after edge N until the next accepted read or reset.
- Back-to-back reads every cycle are supported with no bubbles. RD_VALID stays high for consecutive reads.
- There is no handshake stall; the block is always ready.

## Test plan
- Reset contents: assert RESET for 1 cycle, then read every index pair (i, i) for i = 0..31.
  - Required: 0 everywhere except index 29 = 32'h03FFFFFF.
  - RD_VALID = 0 during reset and 1 after each read.
- Write/read sweep: write DATA_W = 32'hA5A50000 + i to each index 1..31, then read (i, 31−i).
  - Required: each port returns its pattern; index 0 returns 0.
- R0 protection: write 32'hDEADBEEF to index 0 while reading (0, 0) in the same cycle, then read (0, 0) again.
  - Required: both reads return 32'h0.
- Bypass: with index 5 = 32'h11111111, in one cycle issue WRITE index 5 = 32'h22222222 and READ (5, 6).
  - Required: DATA_R1 = 32'h22222222 and DATA_R2 = old index 6.
  - A following read of index 5 also returns 32'h22222222.
- Hold: read (3, 4), then deassert READ for 4 cycles while writing new values to 3 and 4.
  - Required: DATA_R1/R2 unchanged, and RD_VALID = 0 for those 4 cycles.
- Reset mid-stream: with DATA_R1 = 32'h12345678 and a write to index 29 pending, assert RESET together with WRITE and READ.
  - Required: outputs become 0 and index 29 reads 32'h03FFFFFF afterwards.
